// File: rtl/npc_bpred_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : npc_pkg (package)
//  Description : Shared encodings and helpers for the next-PC / branch
//                prediction slice: jump kinds, 2-bit counter states and
//                saturating counter arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    // Jump kind carried with the ID-stage instruction
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    // 2-bit saturating counter states; the MSB is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Per-entry status bits; tag/target widths depend on the instance and
    // therefore live in the BTB module's own entry type.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_status_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc_bpred_btb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : btb_2bit
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                counters. Combinational lookup on the fetch PC, clocked
//                update from the resolved ID-stage instruction, asynchronous
//                clear of every entry.
//  Ports       : clk, rst_n        - clock, async active-low clear
//                i_lk_pc           - fetch word address to look up
//                o_lk_hit/ctr/target - lookup result (old contents on a
//                                    same-cycle update)
//                i_up_en           - update strobe (ID valid and not stalled)
//                i_up_pc           - word address of resolved instruction
//                i_up_is_branch, i_up_br_taken, i_up_jump, i_up_target
//                                  - resolution outcome driving the policy
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_2bit
    import npc_pkg::*;
#(
    parameter int PC_W        = 30,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] i_lk_pc,
    output logic            o_lk_hit,
    output logic [1:0]      o_lk_ctr,
    output logic [PC_W-1:0] o_lk_target,
    input  logic            i_up_en,
    input  logic [PC_W-1:0] i_up_pc,
    input  logic            i_up_is_branch,
    input  logic            i_up_br_taken,
    input  logic [1:0]      i_up_jump,
    input  logic [PC_W-1:0] i_up_target
);

    localparam int c_IDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W = PC_W - c_IDX_W;

    typedef struct packed {
        logic               valid;
        logic [c_TAG_W-1:0] tag;
        logic [PC_W-1:0]    target;
        logic [1:0]         ctr;
    } btb_entry_t;

    btb_entry_t r_entry [BTB_ENTRIES];

    logic [c_IDX_W-1:0] w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic [c_IDX_W-1:0] w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_up_hit;
    logic               w_we;
    btb_entry_t         w_new;

    // ---------------- lookup ----------------
    assign w_lk_idx    = i_lk_pc[c_IDX_W-1:0];
    assign w_lk_tag    = i_lk_pc[PC_W-1:c_IDX_W];
    assign o_lk_hit    = r_entry[w_lk_idx].valid && (r_entry[w_lk_idx].tag == w_lk_tag);
    assign o_lk_ctr    = r_entry[w_lk_idx].ctr;
    assign o_lk_target = r_entry[w_lk_idx].target;

    // ---------------- update policy ----------------
    assign w_up_idx = i_up_pc[c_IDX_W-1:0];
    assign w_up_tag = i_up_pc[PC_W-1:c_IDX_W];
    assign w_up_hit = r_entry[w_up_idx].valid && (r_entry[w_up_idx].tag == w_up_tag);

    always_comb begin
        w_we  = 1'b0;
        w_new = r_entry[w_up_idx];
        if (i_up_en) begin
            if (i_up_jump == JUMP_J) begin
                // Unconditional direct jumps always allocate as strongly taken
                w_we         = 1'b1;
                w_new.valid  = 1'b1;
                w_new.tag    = w_up_tag;
                w_new.target = i_up_target;
                w_new.ctr    = ST;
            end else if (i_up_jump == JUMP_JR) begin
                // Register-indirect targets are not cached; drop stale entries
                if (w_up_hit) begin
                    w_we        = 1'b1;
                    w_new.valid = 1'b0;
                end
            end else if (i_up_is_branch) begin
                if (i_up_br_taken) begin
                    w_we         = 1'b1;
                    w_new.target = i_up_target;
                    if (w_up_hit) begin
                        w_new.ctr = sat_inc(r_entry[w_up_idx].ctr);
                    end else begin
                        w_new.valid = 1'b1;
                        w_new.tag   = w_up_tag;
                        w_new.ctr   = WT;
                    end
                end else if (w_up_hit) begin
                    w_we      = 1'b1;
                    w_new.ctr = sat_dec(r_entry[w_up_idx].ctr);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
        end else if (w_we) begin
            r_entry[w_up_idx] <= w_new;
        end
    end

endmodule
`default_nettype wire

// File: rtl/npc_bpred.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : npc_bpred
//  Description : Next-PC unit with BTB-based prediction. Owns the fetch PC,
//                predicts the next fetch address in IF, resolves branches and
//                jumps in ID, and redirects/flushes IF on a mispredict.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                stall                      - hold PC, block redirect/update
//                pc, pred_taken, pred_target - IF fetch address + prediction
//                id_*                       - ID-stage instruction and the
//                                             prediction it was fetched with
//                flush                      - kill the instruction in IF
//  Notes       : J targets splice the upper 4 bits of pc+1 onto a 26-bit
//                field, so ADDR_W is expected to be 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_bpred
    import npc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic [ADDR_W-3:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-3:0] pred_target,
    input  logic              id_valid,
    input  logic [ADDR_W-3:0] id_pc,
    input  logic              id_is_branch,
    input  logic              id_branch_ok,
    input  logic [1:0]        id_jump,
    input  logic [25:0]       id_target,
    input  logic [ADDR_W-1:0] id_busA,
    input  logic [ADDR_W-1:0] id_imm16Ext,
    input  logic              id_pred_taken,
    input  logic [ADDR_W-3:0] id_pred_target,
    output logic              flush
);

    localparam int c_PC_W = ADDR_W - 2;

    logic [c_PC_W-1:0] r_pc;

    logic              w_lk_hit;
    logic [1:0]        w_lk_ctr;
    logic [c_PC_W-1:0] w_lk_target;
    logic              w_pred_taken;
    logic [c_PC_W-1:0] w_pred_target;

    logic [c_PC_W-1:0] w_pc1;
    logic [c_PC_W-1:0] w_act_target;
    logic              w_act_taken;
    logic [c_PC_W-1:0] w_act_next;
    logic              w_mispredict;
    logic              w_unused;

    // ---------------- prediction ----------------
    btb_2bit #(
        .PC_W        (c_PC_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_lk_pc        (r_pc),
        .o_lk_hit       (w_lk_hit),
        .o_lk_ctr       (w_lk_ctr),
        .o_lk_target    (w_lk_target),
        .i_up_en        (id_valid & ~stall),
        .i_up_pc        (id_pc),
        .i_up_is_branch (id_is_branch),
        .i_up_br_taken  (id_branch_ok),
        .i_up_jump      (id_jump),
        .i_up_target    (w_act_target)
    );

    assign w_pred_taken  = w_lk_hit & w_lk_ctr[1];
    assign w_pred_target = w_pred_taken ? w_lk_target : r_pc + c_PC_W'(1);

    // ---------------- resolution ----------------
    assign w_pc1       = id_pc + c_PC_W'(1);
    assign w_act_taken = (id_is_branch & id_branch_ok) | (id_jump != JUMP_NONE);

    always_comb begin
        w_act_target = w_pc1 + id_imm16Ext[c_PC_W-1:0];
        case (id_jump)
            JUMP_J:  w_act_target = {w_pc1[c_PC_W-1:26], id_target};
            JUMP_JR: w_act_target = id_busA[ADDR_W-1:2];
            default: w_act_target = w_pc1 + id_imm16Ext[c_PC_W-1:0];
        endcase
    end

    assign w_act_next = w_act_taken ? w_act_target : w_pc1;

    // A wrong target only matters when the instruction actually redirects;
    // flush is held low while reset is asserted.
    assign w_mispredict = rst_n & id_valid & ~stall &
                          ((w_act_taken != id_pred_taken) |
                           (w_act_taken & (w_act_target != id_pred_target)));

    // Offset high bits and JR byte-offset bits are architecturally ignored
    assign w_unused = ^{id_imm16Ext[ADDR_W-1:c_PC_W], id_busA[1:0]};

    // ---------------- PC register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC[ADDR_W-1:2];
        end else if (!stall) begin
            r_pc <= w_mispredict ? w_act_next : w_pred_target;
        end
    end

    assign pc          = r_pc;
    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_target;
    assign flush       = w_mispredict;

endmodule
`default_nettype wire
